// File: rtl/pipe_chain_pkg.sv
// pipe_chain_pkg: shared types and helpers for the pipeline register chain.
//   stage_ctl_e         per-register command (load / hold / bubble / kill)
//   NOP_PAYLOAD_DEFAULT payload used for reset, bubbles and killed slots
//   sat_inc()           saturating increment for counters up to SAT_MAX_W bits
package pipe_chain_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      HOLD   = 2'd1,
      BUBBLE = 2'd2,
      KILL   = 2'd3
   } stage_ctl_e;

   localparam int unsigned SAT_MAX_W = 64;

   localparam logic [SAT_MAX_W-1:0] NOP_PAYLOAD_DEFAULT = '0;

   // Increment i_val, saturating at 2^i_w-1. A shift of 64 yields 0, so the
   // subtraction wraps to all-ones and the full-width case needs no special path.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] i_val,
                                                    input int unsigned          i_w);
      logic [SAT_MAX_W-1:0] w_max;
      w_max = (SAT_MAX_W'(1) << i_w) - SAT_MAX_W'(1);
      return (i_val >= w_max) ? i_val : i_val + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one payload+valid pipeline register driven by a stage command.
//   clock, reset  clock and synchronous active-high reset
//   i_ctl         LOAD / HOLD / BUBBLE / KILL for this cycle
//   i_data        payload loaded on LOAD
//   i_valid       valid bit loaded on LOAD
//   o_data        registered payload (NOP_PAYLOAD after reset/bubble/kill)
//   o_valid       registered valid bit
module pipe_stage_reg
   import pipe_chain_pkg::*;
#(
   parameter int unsigned       WIDTH       = 64,
   parameter logic [WIDTH-1:0]  NOP_PAYLOAD = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  stage_ctl_e       i_ctl,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   // Bubble and kill both leave an empty NOP slot; they differ only in accounting.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_data  <= NOP_PAYLOAD;
         r_valid <= 1'b0;
      end else begin
         case (i_ctl)
            LOAD: begin
               r_data  <= i_data;
               r_valid <= i_valid;
            end
            HOLD: begin
               r_data  <= r_data;
               r_valid <= r_valid;
            end
            BUBBLE, KILL: begin
               r_data  <= NOP_PAYLOAD;
               r_valid <= 1'b0;
            end
            default: begin
               r_data  <= NOP_PAYLOAD;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES pipeline registers with uniform stall/flush handling.
//   clock, reset      clock and synchronous active-high reset
//   in_data/in_valid  next payload/valid per register (slice i = register i)
//   stall_req         bit j: consumer of register j cannot accept this cycle
//   flush_req         bit j: kill register j and every younger register
//   cnt_clear         synchronous clear of the hazard counters
//   out_data/out_valid registered payload/valid per register
//   occupancy         popcount of out_valid
//   stall_cycles, bubble_cycles, flush_cycles  saturating hazard counters
module pipe_stage_chain
   import pipe_chain_pkg::*;
#(
   parameter int unsigned      STAGES      = 4,
   parameter int unsigned      WIDTH       = 64,
   parameter logic [WIDTH-1:0] NOP_PAYLOAD = WIDTH'(NOP_PAYLOAD_DEFAULT),
   parameter int unsigned      CNT_W       = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [STAGES*WIDTH-1:0]       in_data,
   input  logic [STAGES-1:0]             in_valid,
   input  logic [STAGES-1:0]             stall_req,
   input  logic [STAGES-1:0]             flush_req,
   input  logic                          cnt_clear,
   output logic [STAGES*WIDTH-1:0]       out_data,
   output logic [STAGES-1:0]             out_valid,
   output logic [$clog2(STAGES+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]              stall_cycles,
   output logic [CNT_W-1:0]              bubble_cycles,
   output logic [CNT_W-1:0]              flush_cycles
);

   localparam int unsigned OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0] w_freeze;
   logic [STAGES-1:0] w_kill;
   logic [STAGES-1:0] w_bubble;
   logic [OCC_W-1:0]  w_occ;

   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_bubble_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   // Suffix-OR from the oldest register down: a request at j affects all i <= j.
   always_comb begin : blk_prefix
      logic v_stall_acc;
      logic v_flush_acc;
      w_freeze    = '0;
      w_kill      = '0;
      v_stall_acc = 1'b0;
      v_flush_acc = 1'b0;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         v_stall_acc = v_stall_acc | stall_req[i];
         v_flush_acc = v_flush_acc | flush_req[i];
         w_freeze[i] = v_stall_acc;
         w_kill[i]   = v_flush_acc;
      end
   end

   // Register i bubbles when its younger neighbour is stalled but it is free to move.
   assign w_bubble = {stall_req[STAGES-2:0], 1'b0} & ~w_freeze & ~w_kill;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      stage_ctl_e w_ctl;

      always_comb begin
         w_ctl = LOAD;
         if (w_kill[g])
            w_ctl = KILL;
         else if (w_freeze[g])
            w_ctl = HOLD;
         else if (w_bubble[g])
            w_ctl = BUBBLE;
      end

      pipe_stage_reg #(
         .WIDTH       (WIDTH),
         .NOP_PAYLOAD (NOP_PAYLOAD)
      ) u_reg (
         .clock   (clock),
         .reset   (reset),
         .i_ctl   (w_ctl),
         .i_data  (in_data[g*WIDTH +: WIDTH]),
         .i_valid (in_valid[g]),
         .o_data  (out_data[g*WIDTH +: WIDTH]),
         .o_valid (out_valid[g])
      );
   end

   // Hazard counters; clear wins over increment.
   always_ff @(posedge clock) begin
      if (reset || cnt_clear) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (|stall_req)
            r_stall_cnt  <= CNT_W'(sat_inc(SAT_MAX_W'(r_stall_cnt), CNT_W));
         if (|w_bubble)
            r_bubble_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(r_bubble_cnt), CNT_W));
         if (|flush_req)
            r_flush_cnt  <= CNT_W'(sat_inc(SAT_MAX_W'(r_flush_cnt), CNT_W));
      end
   end

   assign stall_cycles  = r_stall_cnt;
   assign bubble_cycles = r_bubble_cnt;
   assign flush_cycles  = r_flush_cnt;

   // Occupancy follows the registered valid bits with no added latency.
   always_comb begin
      w_occ = '0;
      for (int i = 0; i < int'(STAGES); i++)
         w_occ = w_occ + OCC_W'(out_valid[i]);
   end

   assign occupancy = w_occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed checks of pipe_stage_chain (STAGES=4, WIDTH=32,
// CNT_W=4). The bench plays the stage logic: register i-1's output feeds
// register i, and a source value feeds register 0.
module tb_pipe_stage_chain;

   localparam logic [31:0] NOP = 32'hDEAD_BEEF;

   logic          clock;
   logic          reset;
   logic [127:0]  in_data;
   logic [3:0]    in_valid;
   logic [3:0]    stall_req;
   logic [3:0]    flush_req;
   logic          cnt_clear;
   logic [127:0]  out_data;
   logic [3:0]    out_valid;
   logic [2:0]    occupancy;
   logic [3:0]    stall_cycles;
   logic [3:0]    bubble_cycles;
   logic [3:0]    flush_cycles;

   logic [31:0]   src;
   logic          src_v;

   int n_cmp;
   int n_err;

   pipe_stage_chain #(
      .STAGES      (4),
      .WIDTH       (32),
      .NOP_PAYLOAD (NOP),
      .CNT_W       (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .stall_req     (stall_req),
      .flush_req     (flush_req),
      .cnt_clear     (cnt_clear),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .occupancy     (occupancy),
      .stall_cycles  (stall_cycles),
      .bubble_cycles (bubble_cycles),
      .flush_cycles  (flush_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Chain feed-through: register i loads what register i-1 currently holds.
   always_comb begin
      in_data  = {out_data[95:0], src};
      in_valid = {out_valid[2:0], src_v};
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_chain(input string tag, input logic [31:0] e3, input logic [31:0] e2,
                              input logic [31:0] e1, input logic [31:0] e0,
                              input logic [3:0] ev, input logic [2:0] eocc);
      check({tag, ".d3"},  64'(out_data[127:96]), 64'(e3));
      check({tag, ".d2"},  64'(out_data[95:64]),  64'(e2));
      check({tag, ".d1"},  64'(out_data[63:32]),  64'(e1));
      check({tag, ".d0"},  64'(out_data[31:0]),   64'(e0));
      check({tag, ".vld"}, 64'(out_valid),        64'(ev));
      check({tag, ".occ"}, 64'(occupancy),        64'(eocc));
   endtask

   task automatic check_cnt(input string tag, input logic [3:0] es, input logic [3:0] eb,
                            input logic [3:0] ef);
      check({tag, ".stall"},  64'(stall_cycles),  64'(es));
      check({tag, ".bubble"}, 64'(bubble_cycles), 64'(eb));
      check({tag, ".flush"},  64'(flush_cycles),  64'(ef));
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b1;
      stall_req = 4'b0000;
      flush_req = 4'b0000;
      cnt_clear = 1'b0;
      src       = 32'h0;
      src_v     = 1'b0;
      step();
      step();
      check_chain("reset", NOP, NOP, NOP, NOP, 4'b0000, 3'd0);
      check_cnt("reset", 4'd0, 4'd0, 4'd0);

      // Stream 0x10.. with no requests: oldest register shows 0x10 after 4 edges.
      reset = 1'b0;
      src_v = 1'b1;
      for (int k = 0; k < 4; k++) begin
         src = 32'h10 + 32'(k);
         step();
      end
      check_chain("stream", 32'h10, 32'h11, 32'h12, 32'h13, 4'b1111, 3'd4);
      check_cnt("stream", 4'd0, 4'd0, 4'd0);

      // Stall at boundary 1 for two cycles: 0/1 hold, 2 bubbles, 3 loads.
      stall_req = 4'b0010;
      src       = 32'h14;
      step();
      check_chain("stall1", 32'h11, NOP, 32'h12, 32'h13, 4'b1011, 3'd3);
      check_cnt("stall1", 4'd1, 4'd1, 4'd0);
      step();
      check_chain("stall2", NOP, NOP, 32'h12, 32'h13, 4'b0011, 3'd2);
      check_cnt("stall2", 4'd2, 4'd2, 4'd0);

      // Release with counter clear.
      stall_req = 4'b0000;
      cnt_clear = 1'b1;
      step();
      check_chain("release", NOP, 32'h12, 32'h13, 32'h14, 4'b0111, 3'd3);
      check_cnt("release", 4'd0, 4'd0, 4'd0);

      // Flush at register 0 only: 0 killed, 1..3 load.
      cnt_clear = 1'b0;
      flush_req = 4'b0001;
      src       = 32'h15;
      step();
      check_chain("flush0", 32'h12, 32'h13, 32'h14, NOP, 4'b1110, 3'd3);
      check_cnt("flush0", 4'd0, 4'd0, 4'd1);

      // Refill the chain, clearing counters on the last edge.
      flush_req = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         src       = 32'h16 + 32'(k);
         cnt_clear = (k == 3);
         step();
      end
      check_chain("refill", 32'h16, 32'h17, 32'h18, 32'h19, 4'b1111, 3'd4);
      check_cnt("refill", 4'd0, 4'd0, 4'd0);

      // Flush at 2 with stall at 3: 0..2 killed, 3 holds, no bubble.
      cnt_clear = 1'b0;
      flush_req = 4'b0100;
      stall_req = 4'b1000;
      src       = 32'h1A;
      step();
      check_chain("flush_stall", 32'h16, NOP, NOP, NOP, 4'b1000, 3'd1);
      check_cnt("flush_stall", 4'd1, 4'd0, 4'd1);

      flush_req = 4'b0000;
      stall_req = 4'b0000;
      cnt_clear = 1'b1;
      src       = 32'h1B;
      step();
      check_chain("after_fs", NOP, NOP, NOP, 32'h1B, 4'b0001, 3'd1);
      check_cnt("after_fs", 4'd0, 4'd0, 4'd0);

      // Long stall at boundary 0: counters saturate at 15.
      cnt_clear = 1'b0;
      stall_req = 4'b0001;
      src       = 32'h1C;
      for (int k = 0; k < 15; k++) step();
      check_cnt("sat15", 4'd15, 4'd15, 4'd0);
      for (int k = 0; k < 5; k++) step();
      check_cnt("sat20", 4'd15, 4'd15, 4'd0);
      check_chain("sat_hold", NOP, NOP, NOP, 32'h1B, 4'b0001, 3'd1);
      cnt_clear = 1'b1;
      step();
      check_cnt("clr_win", 4'd0, 4'd0, 4'd0);
      cnt_clear = 1'b0;
      step();
      check_cnt("clr_next", 4'd1, 4'd1, 4'd0);

      // Fill the chain, then stall the whole chain for 3 cycles.
      stall_req = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         src = 32'h20 + 32'(k);
         step();
      end
      check_chain("fill2", 32'h20, 32'h21, 32'h22, 32'h23, 4'b1111, 3'd4);
      stall_req = 4'b1000;
      src       = 32'h24;
      for (int k = 0; k < 3; k++) step();
      check_chain("freeze_all", 32'h20, 32'h21, 32'h22, 32'h23, 4'b1111, 3'd4);
      check_cnt("freeze_all", 4'd4, 4'd1, 4'd0);

      // Reset during the stall wipes everything in one cycle.
      reset = 1'b1;
      step();
      check_chain("mid_reset", NOP, NOP, NOP, NOP, 4'b0000, 3'd0);
      check_cnt("mid_reset", 4'd0, 4'd0, 4'd0);

      reset     = 1'b0;
      stall_req = 4'b0000;
      src       = 32'h30;
      step();
      check_chain("post_reset", NOP, NOP, NOP, 32'h30, 4'b0001, 3'd1);
      check_cnt("post_reset", 4'd0, 4'd0, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of STAGES pipeline registers with per-boundary stall and flush requests, valid tracking, automatic bubble insertion and saturating hazard counters. It generalises the CPU's fixed four-register pipeline bank: stage count and payload width are parameters, and the old one-off stall/branch/exception cases become one uniform hold/bubble/kill rule. It sits between the stage datapaths of the core; stage logic drives `in_*` and consumes `out_*`.

## Interface
- `STAGES`, 4: number of pipeline registers (≥2); index 0 is youngest (fetch side).
- `WIDTH`, 64: payload bits per register.
- `NOP_PAYLOAD`, '0: payload loaded on reset, bubble or kill.
- `CNT_W`, 32: hazard counter width.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset, both fixed.
- `in_data`  in  STAGES*WIDTH  next payload for register i at slice [i*WIDTH +: WIDTH].
- `in_valid`  in  STAGES  next valid bit for register i.
- `stall_req`  in  STAGES  bit j: consumer of register j cannot accept this cycle.
- `flush_req`  in  STAGES  bit j: kill register j and all younger registers.
- `cnt_clear`  in  1  synchronous clear of all three counters.
- `out_data`  out  STAGES*WIDTH  registered payloads; reset NOP_PAYLOAD in every slice.
- `out_valid`  out  STAGES  registered valid bits; reset 0.
- `occupancy`  out  $clog2(STAGES+1)  popcount of out_valid (combinational); reset 0.
- `stall_cycles`, `bubble_cycles`, `flush_cycles`  out  CNT_W each  saturating counters; reset 0.

## Operation
- Derived per register i: `freeze[i]` = OR of stall_req[j] for j≥i; `kill[i]` = OR of flush_req[j] for j≥i.
- Next state of register i, priority order:
  - reset → valid 0, data NOP_PAYLOAD.
  - kill[i] → valid 0, data NOP_PAYLOAD.
  - freeze[i] → hold data and valid.
  - i>0 and stall_req[i-1] (freeze[i-1] without freeze[i]) → bubble: valid 0, data NOP_PAYLOAD.
  - otherwise → load in_data slice i, in_valid[i].
- Stall at oldest register (j=STAGES-1) freezes the whole chain; no bubble is produced.
- Flush beats stall on killed registers; non-killed registers obey stall rules unchanged in the same cycle.
- Flush at j loads register j+1 normally (instruction causing the flush retires downstream).
- Counters, saturating at 2^CNT_W-1, no wrap:
  - `stall_cycles` +1 in any cycle with stall_req≠0 and no reset.
  - `bubble_cycles` +1 in any cycle where at least one register takes a bubble and is not killed.
  - `flush_cycles` +1 in any cycle with flush_req≠0.
  - `cnt_clear` forces all to 0; clear beats increment in the same cycle.
- Reset mid-operation discards all in-flight payloads and counters in one cycle; no partial state survives.

## Timing
- Latency: in_* sampled at posedge N appear on out_* after that edge (1 cycle per register).
- stall_req/flush_req act in the cycle they are high; no registered requests, no lookahead.
- Held register keeps out_* stable for every cycle its freeze is high, indefinitely.
- Counter outputs update on the same edge as the qualifying event; occupancy tracks out_valid with zero latency.
- No combinational path from in_* to out_*; requests reach out_* only through the register.

## Structure
- Package `pipe_chain_pkg`: `stage_ctl_e` enum {LOAD, HOLD, BUBBLE, KILL}, saturating-increment function, default `NOP_PAYLOAD` constant.
- Sub-module `pipe_stage_reg`: one WIDTH+1 register taking a `stage_ctl_e` command; instantiated STAGES times by generate.
- Top computes freeze/kill prefix-ORs, per-stage command, counters and popcount.

## Test plan
- STAGES=4, WIDTH=32: reset, then stream valid payloads 0x10,0x11,… with no requests → out slice 3 shows 0x10 after 4 edges, occupancy 4, all counters 0.
- stall_req=4'b0010 for 2 cycles → registers 0,1 hold values; register 2 takes bubble (valid 0, NOP) both cycles; register 3 loads; stall_cycles=2, bubble_cycles=2.
- flush_req=4'b0001 with no stall → register 0 killed, 1–3 load; flush_cycles=1, occupancy drops by ≤1.
- flush_req=4'b0100 and stall_req=4'b1000 same cycle → registers 0–2 killed, register 3 holds; counters stall=1, flush=1, bubble=0.
- CNT_W=4, stall held 20 cycles → stall_cycles saturates at 15; cnt_clear with stall still high → reads 0 next cycle, then 1.
- Assert reset during a 3-cycle stall with full chain → next cycle out_valid=0, all slices NOP_PAYLOAD, counters 0; stall ignored that cycle.
